// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register with valid bit,
//               flush, NOP bubbles, delay-slot feedback and perf counters.
// Revision    : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int              DATA_W    = 64,
  parameter int              DBG_W     = 32,
  parameter int              STALL_W   = 6,
  parameter int              STAGE     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter bit              DBG_PASS  = 1'b1,
  parameter int              CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic               in_valid,
  input  logic [DBG_W-1:0]   in_dbg,
  input  logic               in_next_dslot,
  output logic [DATA_W-1:0]  out_payload,
  output logic               out_valid,
  output logic [DBG_W-1:0]   out_dbg,
  output logic               out_dslot,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam logic [DBG_W-1:0] c_DBG_ZERO = {DBG_W{1'b0}};
  localparam logic [CNT_W-1:0] c_CNT_ZERO = {CNT_W{1'b0}};

  logic [DATA_W-1:0] r_payload;
  logic              r_valid;
  logic [DBG_W-1:0]  r_dbg;
  logic              r_dslot;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_hold_cnt;

  logic w_up;
  logic w_dn;
  logic w_unused_stall;

  assign w_up = stall[STAGE];
  assign w_dn = stall[STAGE+1];
  // Only the two neighbouring stall bits matter; the rest are deliberately ignored.
  assign w_unused_stall = ^stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_payload    <= NOP_VALUE;
      r_valid      <= 1'b0;
      r_dbg        <= c_DBG_ZERO;
      r_dslot      <= 1'b0;
      r_bubble_cnt <= c_CNT_ZERO;
      r_hold_cnt   <= c_CNT_ZERO;
    end else if (flush) begin
      r_payload <= NOP_VALUE;
      r_valid   <= 1'b0;
      r_dbg     <= c_DBG_ZERO;
      r_dslot   <= 1'b0;
    end else if (!w_up) begin
      r_payload <= in_valid ? in_payload : NOP_VALUE;
      r_valid   <= in_valid;
      r_dbg     <= in_dbg;
      r_dslot   <= in_next_dslot;
    end else if (!w_dn) begin
      // Downstream keeps moving while upstream is stopped: inject a bubble.
      r_payload <= NOP_VALUE;
      r_valid   <= 1'b0;
      r_dbg     <= DBG_PASS ? in_dbg : c_DBG_ZERO;
      if (!(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end else begin
      if (!(&r_hold_cnt)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign out_payload = r_payload;
  assign out_valid   = r_valid;
  assign out_dbg     = r_dbg;
  assign out_dslot   = r_dslot;
  assign bubble_cnt  = r_bubble_cnt;
  assign hold_cnt    = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench; default instance plus a CNT_W=2, DBG_PASS=0,
//               non-zero NOP instance driven by the same directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_pipe_stage_reg;

  localparam logic [63:0] c_NOP2 = 64'hFFFF_0000_0000_00FF;

  typedef struct {
    logic        nop;
    logic [63:0] pay;
    logic        valid;
    logic [31:0] dbg;
    logic [31:0] dbg2;
    logic        dslot;
    int          bcnt;
    int          hcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] in_payload;
  logic        in_valid;
  logic [31:0] in_dbg;
  logic        in_next_dslot;

  logic [63:0] a_payload, b_payload;
  logic        a_valid, b_valid;
  logic [31:0] a_dbg, b_dbg;
  logic        a_dslot, b_dslot;
  logic [15:0] a_bcnt, a_hcnt;
  logic [1:0]  b_bcnt, b_hcnt;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .in_dbg(in_dbg),
    .in_next_dslot(in_next_dslot),
    .out_payload(a_payload), .out_valid(a_valid), .out_dbg(a_dbg),
    .out_dslot(a_dslot), .bubble_cnt(a_bcnt), .hold_cnt(a_hcnt)
  );

  pipe_stage_reg #(.CNT_W(2), .DBG_PASS(1'b0), .NOP_VALUE(c_NOP2)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .in_dbg(in_dbg),
    .in_next_dslot(in_next_dslot),
    .out_payload(b_payload), .out_valid(b_valid), .out_dbg(b_dbg),
    .out_dslot(b_dslot), .bubble_cnt(b_bcnt), .hold_cnt(b_hcnt)
  );

  function automatic logic [63:0] clip3(input int v);
    return (v > 3) ? 64'd3 : 64'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the hand-computed post-edge result.
  task automatic step(input logic r, input logic f, input logic [5:0] s,
                      input logic v, input logic [63:0] p, input logic [31:0] d,
                      input logic ds, input exp_t e);
    @(negedge clk);
    rst = r; flush = f; stall = s;
    in_valid = v; in_payload = p; in_dbg = d; in_next_dslot = ds;
    q.push_back(e);
  endtask

  function automatic exp_t mk(input logic nop, input logic [63:0] pay, input logic valid,
                              input logic [31:0] dbg, input logic [31:0] dbg2,
                              input logic dslot, input int bcnt, input int hcnt);
    exp_t e;
    e.nop = nop; e.pay = pay; e.valid = valid; e.dbg = dbg; e.dbg2 = dbg2;
    e.dslot = dslot; e.bcnt = bcnt; e.hcnt = hcnt;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a_payload", a_payload, e.nop ? 64'h0 : e.pay);
        chk("a_valid",   64'(a_valid), 64'(e.valid));
        chk("a_dbg",     64'(a_dbg),   64'(e.dbg));
        chk("a_dslot",   64'(a_dslot), 64'(e.dslot));
        chk("a_bubble_cnt", 64'(a_bcnt), 64'(e.bcnt));
        chk("a_hold_cnt",   64'(a_hcnt), 64'(e.hcnt));
        chk("b_payload", b_payload, e.nop ? c_NOP2 : e.pay);
        chk("b_valid",   64'(b_valid), 64'(e.valid));
        chk("b_dbg",     64'(b_dbg),   64'(e.dbg2));
        chk("b_dslot",   64'(b_dslot), 64'(e.dslot));
        chk("b_bubble_cnt", 64'(b_bcnt), clip3(e.bcnt));
        chk("b_hold_cnt",   64'(b_hcnt), clip3(e.hcnt));
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    in_valid = 1'b1; in_payload = 64'hDEAD; in_dbg = 32'h55; in_next_dslot = 1'b1;

    // reset, two cycles
    step(1, 0, 6'b000000, 1, 64'hDEAD, 32'h55, 1, mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    step(1, 0, 6'b000000, 1, 64'hDEAD, 32'h55, 1, mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    // advance
    step(0, 0, 6'b000000, 1, 64'h1234, 32'h11, 1, mk(0, 64'h1234, 1, 32'h11, 32'h11, 1, 0, 0));
    // bubble: dslot holds, dbg passes only on instance A
    step(0, 0, 6'b000100, 1, 64'h9999, 32'h21, 0, mk(1, 0, 0, 32'h21, 32'h0, 1, 1, 0));
    // advance with dn=1 and invalid input -> NOP payload
    step(0, 0, 6'b001000, 0, 64'h7777, 32'h33, 0, mk(1, 0, 0, 32'h33, 32'h33, 0, 1, 0));
    // advance; non-neighbour stall bits ignored
    step(0, 0, 6'b110000, 1, 64'hABCD, 32'h44, 1, mk(0, 64'hABCD, 1, 32'h44, 32'h44, 1, 1, 0));
    // hold x3
    for (int i = 1; i <= 3; i++)
      step(0, 0, 6'b001100, 0, 64'h5555, 32'h66, 0, mk(0, 64'hABCD, 1, 32'h44, 32'h44, 1, 1, i));
    // bubble x4 -> bubble count 5; instance B saturates at 3
    for (int i = 0; i < 4; i++)
      step(0, 0, 6'b000100, 1, 64'h6666, 32'h70 + 32'(i), 0,
           mk(1, 0, 0, 32'h70 + 32'(i), 32'h0, 1, 2 + i, 3));
    // flush during full stall: cleared, counters kept
    step(0, 1, 6'b001100, 1, 64'h8888, 32'h99, 1, mk(1, 0, 0, 32'h0, 32'h0, 0, 5, 3));
    // stall still present next edge -> hold
    step(0, 0, 6'b001100, 1, 64'h8888, 32'h99, 1, mk(1, 0, 0, 32'h0, 32'h0, 0, 5, 4));
    // flush during bubble condition: no bubble counted
    step(0, 1, 6'b000100, 1, 64'h8888, 32'h98, 1, mk(1, 0, 0, 32'h0, 32'h0, 0, 5, 4));
    // advance
    step(0, 0, 6'b000000, 1, 64'h0F0F, 32'h12, 0, mk(0, 64'h0F0F, 1, 32'h12, 32'h12, 0, 5, 4));
    // reset during full stall clears counters
    step(1, 0, 6'b001100, 1, 64'h4321, 32'h77, 1, mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    // bubble after reset
    step(0, 0, 6'b000100, 1, 64'h4321, 32'h5A, 1, mk(1, 0, 0, 32'h5A, 32'h0, 0, 1, 0));

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    done = 1'b1;
  end

  initial begin : finish_ctl
    fork
      wait (done);
      #5000;
    join_any
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=not_done required=done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
